tag_pool_arbiter: RTL and testbench
===================================

Name: tag_pool_arbiter

Overview:
Parametrised tag manager that issues bus command tags from a free-list FIFO to NUM_CH competing command channels, one grant per cycle, under round-robin arbitration. Per-tag metadata (channel id plus user bits) is stored in a dual-read-port RAM so response and read-data paths can route back to the originating channel. Next-generation tag controller:
- deterministic init length
- in-flight tracking
- outstanding-tag count
- duplicate/stray-return detection

Parameters:
TAG_WIDTH, 8, width of a tag; TAG_COUNT <= 2**TAG_WIDTH.
TAG_COUNT, 256, number of tags managed (0..TAG_COUNT-1).
NUM_CH, 2, number of command channels (1..8).
META_WIDTH, 16, user metadata bits stored per tag.

Ports:
clock  in  1  clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  block enable; low flushes all state
cmd_req  in  NUM_CH  per-channel tag request
cmd_meta  in  NUM_CH*META_WIDTH  per-channel metadata; channel i at bits [i*META_WIDTH +: META_WIDTH]
cmd_grant  out  NUM_CH  one-hot grant; combinational, same cycle as request
cmd_tag  out  TAG_WIDTH  tag issued with the grant (free-list head)
rsp_valid  in  1  tag return from response interface
rsp_tag  in  TAG_WIDTH  returned tag
rsp_meta_valid  out  1  registered rsp_valid qualified by in-flight check
rsp_ch_out  out  $clog2(NUM_CH) or 1  channel that owned rsp_tag
rsp_meta_out  out  META_WIDTH  metadata of rsp_tag
rd_tag  in  TAG_WIDTH  read-data tag lookup address
rd_ch_out  out  $clog2(NUM_CH) or 1  owner channel of rd_tag
rd_meta_out  out  META_WIDTH  metadata of rd_tag
tags_ready  out  1  state READY and free list non-empty
outstanding  out  TAG_WIDTH+1  tags currently in flight
dup_return_err  out  1  sticky: return of a tag not in flight

Behaviour:
Reset and enable:
- rstn is asynchronous, active-low. On reset: all outputs 0, state RESET, free list empty, in-flight vector cleared, RR pointer = NUM_CH-1 (first priority is channel 0).
- enabled_in is registered once (enabled). While enabled = 0, state is forced to RESET; free list, in-flight vector, outstanding and dup_return_err are cleared.

State machine (advances only when enabled = 1):
- RESET -> INIT after 1 cycle; init counter = 0.
- INIT: pushes counter value into free list every cycle, counter +1. After pushing TAG_COUNT-1, goes to READY. INIT lasts exactly TAG_COUNT cycles.
- READY: holds until enable drops or reset.

Arbitration:
- Grant only in READY with free list non-empty.
- Winner is the first requesting channel after the RR pointer, wrapping modulo NUM_CH. The pointer updates to the winner on the grant edge.
- Non-requesting channels never advance the pointer. No grants in RESET or INIT.

Grant edge:
- Free list pops; in-flight[cmd_tag] is set.
- RAM[cmd_tag] <= {winner id, winner meta}.
- outstanding +1.

Return handling (response path):
- rsp_valid in READY with in-flight[rsp_tag] = 1: tag pushed to free-list tail; in-flight bit cleared; outstanding -1.
- rsp_valid with in-flight bit 0 (including during INIT): nothing pushed; dup_return_err set (sticky).
- rsp_meta_valid, rsp_ch_out and rsp_meta_out are registered: valid 1 cycle after rsp_valid, and only for legal returns.

Read-data lookup:
- rd_ch_out and rd_meta_out are registered RAM reads of rd_tag, 1-cycle latency, unqualified.

Simultaneous events and boundaries:
- Grant and legal return in the same cycle: both occur; outstanding unchanged. The granted tag cannot equal the returned tag.
- Free list is sized TAG_COUNT and cannot overflow, since only in-flight tags are pushed.
- When all tags are in flight: tags_ready = 0, cmd_grant = 0, outstanding = TAG_COUNT.
- Free list is FIFO order: tags reissue in return order after the initial 0..TAG_COUNT-1 sequence.
- Enable drop mid-operation discards all in-flight state. Late returns after re-enable flag dup_return_err unless that tag has been reissued.

Test Plan:
1. TAG_COUNT=16, enabled_in raised at edge E0 -> tags_ready first high after edge E17; no grant before that; first four grants issue tags 0,1,2,3.
2. NUM_CH=3, all channels requesting continuously in READY -> grants ch0,ch1,ch2,ch0,...; ch1 drops request -> sequence becomes ch0,ch2,ch0,ch2.
3. TAG_COUNT=16, 16 grants with no returns -> outstanding=16, tags_ready=0, cmd_grant=0. Return tag 5 -> next grant issues tag 5; outstanding back to 16.
4. Grant tag 3 to ch1 with meta 0xBEEF, then rsp_valid with rsp_tag=3 -> next cycle rsp_meta_valid=1, rsp_ch_out=1, rsp_meta_out=0xBEEF. rd_tag=3 gives the same values 1 cycle later.
5. rsp_valid with tag 7 never issued (or returned twice) -> dup_return_err=1 and stays high; rsp_meta_valid=0; free list and outstanding unchanged.
6. Same-cycle grant and return with outstanding=4 -> outstanding stays 4. enabled_in deasserted mid-traffic -> outstanding=0, dup_return_err=0, tags_ready=0; re-enable repeats the TAG_COUNT-cycle INIT.

Source files
------------

// File: rtl/tag_pool_arbiter.sv
// Tag pool arbiter: free-list tag issue to round-robin channels,
// per-tag owner/metadata RAM, in-flight tracking and return checks.
module tag_pool_arbiter #(
  parameter int TAG_WIDTH  = 8,
  parameter int TAG_COUNT  = 256,
  parameter int NUM_CH     = 2,
  parameter int META_WIDTH = 16,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enabled_in,
  input  logic [NUM_CH-1:0]            cmd_req,
  input  logic [NUM_CH*META_WIDTH-1:0] cmd_meta,
  output logic [NUM_CH-1:0]            cmd_grant,
  output logic [TAG_WIDTH-1:0]         cmd_tag,
  input  logic                         rsp_valid,
  input  logic [TAG_WIDTH-1:0]         rsp_tag,
  output logic                         rsp_meta_valid,
  output logic [CW-1:0]                rsp_ch_out,
  output logic [META_WIDTH-1:0]        rsp_meta_out,
  input  logic [TAG_WIDTH-1:0]         rd_tag,
  output logic [CW-1:0]                rd_ch_out,
  output logic [META_WIDTH-1:0]        rd_meta_out,
  output logic                         tags_ready,
  output logic [TAG_WIDTH:0]           outstanding,
  output logic                         dup_return_err
);

  localparam int AW = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;
  localparam int OW = TAG_WIDTH + 1;
  localparam int RW = CW + META_WIDTH;

  typedef enum logic [1:0] {
    S_RESET,
    S_INIT,
    S_READY
  } state_t;

  state_t                state;
  logic                  enabled;
  logic [TAG_WIDTH-1:0]  init_cnt;
  logic [TAG_WIDTH-1:0]  fl_mem [TAG_COUNT];
  logic [AW-1:0]         fl_head;
  logic [AW-1:0]         fl_tail;
  logic [OW-1:0]         fl_cnt;
  logic [TAG_COUNT-1:0]  inflight;
  logic [RW-1:0]         meta_ram [TAG_COUNT];
  logic [CW-1:0]         rr_ptr;

  logic                  fl_empty;
  logic                  win_found;
  logic [CW-1:0]         win_id;
  logic                  grant_en;
  logic [META_WIDTH-1:0] win_meta;
  logic [AW-1:0]         gnt_idx;
  logic [AW-1:0]         rsp_idx;
  logic [AW-1:0]         rd_idx;
  logic                  rsp_in_range;
  logic                  rd_in_range;
  logic                  ret_ok;
  logic                  ret_bad;
  logic                  push;
  logic [TAG_WIDTH-1:0]  push_data;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (32'(p) == TAG_COUNT - 1) ? '0 : p + 1'b1;
  endfunction

  assign fl_empty   = (fl_cnt == '0);
  assign tags_ready = (state == S_READY) && !fl_empty;
  assign cmd_tag    = fl_empty ? '0 : fl_mem[fl_head];
  assign gnt_idx    = cmd_tag[AW-1:0];
  assign rsp_idx    = rsp_tag[AW-1:0];
  assign rd_idx     = rd_tag[AW-1:0];

  assign rsp_in_range = 32'(rsp_tag) < TAG_COUNT;
  assign rd_in_range  = 32'(rd_tag) < TAG_COUNT;

  assign ret_ok  = rsp_valid && (state == S_READY)
                && rsp_in_range && inflight[rsp_idx];
  assign ret_bad = rsp_valid && !ret_ok;

  assign push      = (state == S_INIT) || ret_ok;
  assign push_data = (state == S_INIT) ? init_cnt : rsp_tag;

  // Round-robin search starting just after the last winner
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!win_found && cmd_req[idx]) begin
        win_found = 1'b1;
        win_id    = CW'(idx);
      end
    end
  end

  assign grant_en  = tags_ready && win_found;
  assign cmd_grant = grant_en ? (NUM_CH'(1) << win_id) : '0;
  assign win_meta  = cmd_meta[win_id*META_WIDTH +: META_WIDTH];

  // Free-list storage and per-tag owner RAM (no reset needed)
  always_ff @(posedge clock) begin
    if (enabled && push)
      fl_mem[fl_tail] <= push_data;
    if (enabled && grant_en)
      meta_ram[gnt_idx] <= {win_id, win_meta};
  end

  // Control FSM, free-list pointers, in-flight and counters
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled        <= 1'b0;
      state          <= S_RESET;
      init_cnt       <= '0;
      fl_head        <= '0;
      fl_tail        <= '0;
      fl_cnt         <= '0;
      inflight       <= '0;
      outstanding    <= '0;
      dup_return_err <= 1'b0;
      rsp_meta_valid <= 1'b0;
      rr_ptr         <= CW'(NUM_CH - 1);
    end else begin
      enabled <= enabled_in;
      if (!enabled) begin
        state          <= S_RESET;
        init_cnt       <= '0;
        fl_head        <= '0;
        fl_tail        <= '0;
        fl_cnt         <= '0;
        inflight       <= '0;
        outstanding    <= '0;
        dup_return_err <= 1'b0;
        rsp_meta_valid <= 1'b0;
      end else begin
        unique case (state)
          S_RESET: begin
            state    <= S_INIT;
            init_cnt <= '0;
          end
          S_INIT: begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == TAG_WIDTH'(TAG_COUNT - 1))
              state <= S_READY;
          end
          S_READY: state <= S_READY;
          default: state <= S_RESET;
        endcase
        if (push)
          fl_tail <= nxt(fl_tail);
        if (grant_en) begin
          fl_head <= nxt(fl_head);
          rr_ptr  <= win_id;
        end
        fl_cnt <= fl_cnt + OW'(push) - OW'(grant_en);
        if (grant_en)
          inflight[gnt_idx] <= 1'b1;
        if (ret_ok)
          inflight[rsp_idx] <= 1'b0;
        outstanding <= outstanding + OW'(grant_en) - OW'(ret_ok);
        if (ret_bad)
          dup_return_err <= 1'b1;
        rsp_meta_valid <= ret_ok;
      end
    end
  end

  // Registered RAM reads for the response and read-data paths
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rsp_ch_out   <= '0;
      rsp_meta_out <= '0;
      rd_ch_out    <= '0;
      rd_meta_out  <= '0;
    end else begin
      if (ret_ok)
        {rsp_ch_out, rsp_meta_out} <= meta_ram[rsp_idx];
      if (rd_in_range)
        {rd_ch_out, rd_meta_out} <= meta_ram[rd_idx];
      else
        {rd_ch_out, rd_meta_out} <= '0;
    end
  end

endmodule

// File: tb/tb_tag_pool_arbiter.sv
// Scoreboard bench for tag_pool_arbiter: directed traffic with
// expected grants/responses queued and checked by a monitor.
module tb_tag_pool_arbiter;

  localparam int TW = 5;
  localparam int TC = 16;
  localparam int NC = 3;
  localparam int MW = 16;
  localparam int CW = 2;

  logic              clock;
  logic              rstn;
  logic              enabled_in;
  logic [NC-1:0]     cmd_req;
  logic [NC*MW-1:0]  cmd_meta;
  logic [NC-1:0]     cmd_grant;
  logic [TW-1:0]     cmd_tag;
  logic              rsp_valid;
  logic [TW-1:0]     rsp_tag;
  logic              rsp_meta_valid;
  logic [CW-1:0]     rsp_ch_out;
  logic [MW-1:0]     rsp_meta_out;
  logic [TW-1:0]     rd_tag;
  logic [CW-1:0]     rd_ch_out;
  logic [MW-1:0]     rd_meta_out;
  logic              tags_ready;
  logic [TW:0]       outstanding;
  logic              dup_return_err;

  tag_pool_arbiter #(
    .TAG_WIDTH(TW), .TAG_COUNT(TC),
    .NUM_CH(NC), .META_WIDTH(MW)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .cmd_req(cmd_req), .cmd_meta(cmd_meta),
    .cmd_grant(cmd_grant), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_meta_valid(rsp_meta_valid),
    .rsp_ch_out(rsp_ch_out), .rsp_meta_out(rsp_meta_out),
    .rd_tag(rd_tag), .rd_ch_out(rd_ch_out),
    .rd_meta_out(rd_meta_out), .tags_ready(tags_ready),
    .outstanding(outstanding),
    .dup_return_err(dup_return_err)
  );

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [TW-1:0] tag;
  } gexp_t;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [MW-1:0] meta;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    checks = 0;
  int    errors = 0;
  logic [CW-1:0] owner [TC];
  logic [MW-1:0] chmeta [NC];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exp_grant(int ch, int tag);
    gexp_t e;
    e.ch  = CW'(ch);
    e.tag = TW'(tag);
    gq.push_back(e);
    owner[tag] = CW'(ch);
  endtask

  task automatic exp_rsp(int tag);
    rexp_t e;
    e.ch   = owner[tag];
    e.meta = chmeta[owner[tag]];
    rq.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents output
  initial begin
    forever begin
      @(negedge clock);
      if (cmd_grant != '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(cmd_grant), 0);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          chk("grant_onehot", 32'(cmd_grant),
              32'(NC'(1) << e.ch));
          chk("grant_tag", 32'(cmd_tag), 32'(e.tag));
        end
      end
      if (rsp_meta_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_meta_valid), 0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rsp_ch", 32'(rsp_ch_out), 32'(e.ch));
          chk("rsp_meta", 32'(rsp_meta_out), 32'(e.meta));
        end
      end
    end
  end

  initial begin
    chmeta[0] = 16'h1111;
    chmeta[1] = 16'hBEEF;
    chmeta[2] = 16'h2222;
    for (int t = 0; t < TC; t++) owner[t] = '0;
    rstn       = 1'b0;
    enabled_in = 1'b0;
    cmd_req    = '0;
    cmd_meta   = {chmeta[2], chmeta[1], chmeta[0]};
    rsp_valid  = 1'b0;
    rsp_tag    = '0;
    rd_tag     = '0;
    #23;
    chk("rst_grant", 32'(cmd_grant), 0);
    chk("rst_ready", 32'(tags_ready), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_dup", 32'(dup_return_err), 0);
    chk("rst_rspv", 32'(rsp_meta_valid), 0);
    rstn = 1'b1;

    // Enable with all channels requesting through INIT
    @(posedge clock);
    #1;
    enabled_in = 1'b1;
    cmd_req    = 3'b111;
    exp_grant(0, 0);
    exp_grant(1, 1);
    exp_grant(2, 2);
    for (int k = 0; k <= 17; k++) begin
      @(posedge clock);
      #1;
      if (k == 16) chk("init_not_ready", 32'(tags_ready), 0);
      if (k == 17) chk("init_ready", 32'(tags_ready), 1);
    end
    cyc(3);
    cmd_req = 3'b010;
    exp_grant(1, 3);
    cyc(1);
    cmd_req = 3'b101;
    exp_grant(2, 4);
    exp_grant(0, 5);
    exp_grant(2, 6);
    exp_grant(0, 7);
    cyc(4);
    cmd_req = '0;
    chk("out_after8", 32'(outstanding), 8);

    // Legal return of tag 3 plus read-data lookup
    rsp_valid = 1'b1;
    rsp_tag   = 5'd3;
    rd_tag    = 5'd3;
    exp_rsp(3);
    cyc(1);
    chk("rd_ch", 32'(rd_ch_out), 1);
    chk("rd_meta", 32'(rd_meta_out), 32'hBEEF);
    chk("out_after_ret", 32'(outstanding), 7);
    chk("dup_clean", 32'(dup_return_err), 0);

    // Double return and never-issued tag
    cyc(1);
    chk("dup_set", 32'(dup_return_err), 1);
    chk("dup_out", 32'(outstanding), 7);
    rsp_tag = 5'd12;
    cyc(1);
    chk("stray_out", 32'(outstanding), 7);
    rsp_valid = 1'b0;
    cyc(1);
    chk("dup_sticky", 32'(dup_return_err), 1);

    // Exhaust the pool; FIFO reissue of returned tag 3
    cmd_req = 3'b001;
    for (int t = 8; t < TC; t++) exp_grant(0, t);
    exp_grant(0, 3);
    cyc(9);
    chk("full_out", 32'(outstanding), 16);
    chk("full_ready", 32'(tags_ready), 0);
    chk("full_grant", 32'(cmd_grant), 0);
    rsp_valid = 1'b1;
    rsp_tag   = 5'd5;
    exp_rsp(5);
    exp_grant(0, 5);
    cyc(1);
    rsp_valid = 1'b0;
    cyc(1);
    cmd_req = '0;
    chk("refill_out", 32'(outstanding), 16);

    // Drain down to four in flight, then grant+return together
    for (int t = 4; t < TC; t++) begin
      rsp_valid = 1'b1;
      rsp_tag   = TW'(t);
      exp_rsp(t);
      cyc(1);
    end
    chk("drain_out", 32'(outstanding), 4);
    cmd_req = 3'b001;
    rsp_tag = 5'd0;
    exp_rsp(0);
    exp_grant(0, 4);
    cyc(1);
    cmd_req   = '0;
    rsp_valid = 1'b0;
    chk("same_cycle_out", 32'(outstanding), 4);

    // Enable drop flushes everything; re-enable re-inits
    enabled_in = 1'b0;
    cyc(2);
    chk("flush_out", 32'(outstanding), 0);
    chk("flush_dup", 32'(dup_return_err), 0);
    chk("flush_ready", 32'(tags_ready), 0);
    enabled_in = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clock);
      #1;
      if (k == 16) chk("reinit_not_ready", 32'(tags_ready), 0);
      if (k == 17) chk("reinit_ready", 32'(tags_ready), 1);
    end
    rsp_valid = 1'b1;
    rsp_tag   = 5'd9;
    cyc(1);
    rsp_valid = 1'b0;
    chk("late_dup", 32'(dup_return_err), 1);
    chk("late_out", 32'(outstanding), 0);
    cmd_req = 3'b100;
    exp_grant(2, 0);
    cyc(1);
    cmd_req = '0;
    chk("reinit_first", 32'(outstanding), 1);
    cyc(2);
    chk("grant_q_empty", 32'(gq.size()), 0);
    chk("rsp_q_empty", 32'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
